// File: rtl/sobel_pkg.sv
// sobel_pkg: shared pixel/window types, address defaults and saturation helper.
package sobel_pkg;
  localparam logic [31:0] TOP_BASE_DEF = 32'h0800_0000;
  localparam int PIXEL_BYTES_DEF = 4;
  typedef logic [7:0] pixel_t;
  // [row][col]: row 0 = top, col 0 = oldest (left), col 2 = newest (right)
  typedef pixel_t [2:0][2:0] window_t;
  function automatic pixel_t sat8(input logic [11:0] v);
    return (v > 12'd255) ? 8'hFF : v[7:0];
  endfunction
endpackage

// File: rtl/sobel_mag.sv
// sobel_mag: combinational |Gx|+|Gy| of a 3x3 window, saturated to 8 bits.
// With SOBEL_THRESH_EN defined the result is binarised at THRESHOLD.
module sobel_mag
  import sobel_pkg::*;
#(
  parameter pixel_t THRESHOLD = 8'd64
) (
  input  window_t win,
  output pixel_t  mag
);
`ifdef SOBEL_THRESH_EN
  localparam bit THRESH = 1'b1;
`else
  localparam bit THRESH = 1'b0;
`endif
  function automatic logic signed [10:0] p(input pixel_t v);
    return signed'({3'b000, v});
  endfunction
  logic signed [10:0] gx, gy;
  logic [10:0] ax, ay;
  logic [11:0] sum;
  assign gx = (p(win[0][2]) + (p(win[1][2]) <<< 1) + p(win[2][2]))
            - (p(win[0][0]) + (p(win[1][0]) <<< 1) + p(win[2][0]));
  assign gy = (p(win[2][0]) + (p(win[2][1]) <<< 1) + p(win[2][2]))
            - (p(win[0][0]) + (p(win[0][1]) <<< 1) + p(win[0][2]));
  assign ax = gx[10] ? 11'(-gx) : 11'(gx);
  assign ay = gy[10] ? 11'(-gy) : 11'(gy);
  assign sum = {1'b0, ax} + {1'b0, ay};
  assign mag = THRESH ? ((sum >= 12'(THRESHOLD)) ? 8'hFF : 8'h00) : sat8(sum);
endmodule

// File: rtl/sobel_window_core.sv
// sobel_window_core: 3x3 pixel window, Sobel magnitude and row-address generation.
// Define SOBEL_THRESH_EN to binarise the Sobel output path at THRESHOLD.
module sobel_window_core
  import sobel_pkg::*;
#(
  parameter logic [31:0] TOP_BASE    = TOP_BASE_DEF,
  parameter int          PIXEL_BYTES = PIXEL_BYTES_DEF,
  parameter int          CNTW        = 16,
  parameter pixel_t      THRESHOLD   = 8'd64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [7:0]      data_in,
  input  logic            w_load_size,
  input  logic            w_buffer_load,
  input  logic            w_count_enable,
  input  logic            w_output_load,
  input  logic            w_data_select,
  input  logic            w_flag_clear,
  output logic            w_image_done,
  output logic [31:0]     w_mid_addr,
  output logic [31:0]     w_bot_addr,
  output logic [CNTW-1:0] row_count_out,
  output logic [CNTW-1:0] col_count_out,
  output logic [7:0]      data_out
);
  logic [CNTW-1:0] width, height;
  logic [1:0] ld_cnt;
  logic buf_mid, valid, degen, last;
  pixel_t col_bot, col_mid, mag;
  window_t win;
  sobel_mag #(.THRESHOLD(THRESHOLD)) u_mag (.win(win), .mag(mag));
  assign degen = (width < CNTW'(3)) || (height < CNTW'(3));
  assign last = degen || (row_count_out == height - CNTW'(3) && col_count_out == width - CNTW'(1));
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      width <= '0;
      height <= '0;
      ld_cnt <= '0;
      buf_mid <= 1'b0;
      valid <= 1'b0;
      col_bot <= '0;
      col_mid <= '0;
      win <= '0;
      w_image_done <= 1'b0;
      w_mid_addr <= TOP_BASE;
      w_bot_addr <= TOP_BASE;
      row_count_out <= '0;
      col_count_out <= '0;
      data_out <= '0;
    end else begin
      if (w_output_load) data_out <= (valid && !degen) ? (w_data_select ? mag : win[1][1]) : 8'h00;
      if (w_flag_clear) begin
        row_count_out <= '0;
        col_count_out <= '0;
        win <= '0;
        valid <= 1'b0;
        buf_mid <= 1'b0;
        col_bot <= '0;
        col_mid <= '0;
        w_image_done <= 1'b0;
      end else if (w_load_size) begin
        ld_cnt <= ld_cnt + 2'd1;
        if (ld_cnt == 2'd0) width[7:0] <= data_in;
        if (ld_cnt == 2'd1) width[15:8] <= data_in;
        if (ld_cnt == 2'd2) height[7:0] <= data_in;
        if (ld_cnt == 2'd3) begin
          height[15:8] <= data_in;
          w_mid_addr <= TOP_BASE + 32'(width) * 32'(PIXEL_BYTES);
          w_bot_addr <= TOP_BASE + 32'(width) * 32'(2 * PIXEL_BYTES);
        end
      end else begin
        if (w_count_enable) buf_mid <= 1'b0;
        else if (w_buffer_load) begin
          if (buf_mid) col_mid <= data_in;
          else col_bot <= data_in;
          buf_mid <= 1'b1;
        end
        // the third column byte (top) bypasses the column registers
        if (w_count_enable && !w_image_done) begin
          win[0] <= {data_in, win[0][2:1]};
          win[1] <= {col_mid, win[1][2:1]};
          win[2] <= {col_bot, win[2][2:1]};
          valid <= col_count_out >= CNTW'(2);
          if (last) begin
            w_image_done <= 1'b1;
            col_count_out <= '0;
          end else if (col_count_out == width - CNTW'(1)) begin
            col_count_out <= '0;
            row_count_out <= row_count_out + CNTW'(1);
          end else col_count_out <= col_count_out + CNTW'(1);
        end
      end
    end
endmodule
